// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared state encoding and default chain breakdown for tile config loaders
package clb_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int LUT_BITS = 16;
  localparam int FF_MODE_BITS = 1;
  localparam int MUX_SRAM_BITS = 3;
  localparam int NUM_FLE_IN = 4;
  localparam int CHAIN_LEN_DEF = LUT_BITS + FF_MODE_BITS + NUM_FLE_IN * MUX_SRAM_BITS;
endpackage

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer: packs serial chain-tail bits MSB-first into words; flush emits a left-aligned partial word
module ccff_rb_packer #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              en,
  input  logic              flush,
  input  logic              clr,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int CW = $clog2(WORD_W + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d, sh_n, rb_data_q, rb_data_d;
  logic rb_valid_q, rb_valid_d, emit;
  always_comb begin
    sh_n = sh_q;
    for (int i = 0; i < WORD_W; i++) if (int'(cnt_q) == WORD_W - 1 - i) sh_n[i] = bit_in;
    emit = en && !clr && (flush || cnt_q == CW'(WORD_W - 1));
    cnt_d = (clr || emit) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    sh_d = (clr || emit) ? '0 : en ? sh_n : sh_q;
    rb_data_d = emit ? sh_n : rb_data_q;
    rb_valid_d = emit;
  end
  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sh_q <= '0;
      rb_data_q <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rb_data_q <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end
  assign rb_data = rb_data_q;
  assign rb_valid = rb_valid_q;
endmodule

// File: rtl/clb_ccff_loader.sv
// clb_ccff_loader: serializes bitstream words onto a tile config chain and captures the old contents as readback
module clb_ccff_loader
  import clb_cfg_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int WL_W = $clog2(WORD_W + 1);
  state_t state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WL_W-1:0] word_left_q, word_left_d;
  logic aborted_q, aborted_d, rb_clr, in_run, last_bit;
  int rem;
  always_comb begin
    in_run = state_q == LOAD || state_q == SHIFT;
    rem = CHAIN_LEN - int'(bit_cnt_q);
    last_bit = bit_cnt_q == CNT_W'(CHAIN_LEN - 1);
    state_d = state_q;
    sreg_d = sreg_q;
    bit_cnt_d = bit_cnt_q;
    word_left_d = word_left_q;
    aborted_d = in_run && abort;
    rb_clr = aborted_d;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        bit_cnt_d = '0;
        rb_clr = 1'b1;
      end
      LOAD: if (abort) state_d = IDLE;
        else if (cfg_valid) begin
          sreg_d = cfg_data;
          word_left_d = WL_W'(rem > WORD_W ? WORD_W : rem);
          state_d = SHIFT;
        end
      SHIFT: if (abort) state_d = IDLE;
        else begin
          sreg_d = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          word_left_d = word_left_q - 1'b1;
          if (word_left_q == WL_W'(1)) state_d = last_bit ? DONE : LOAD;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q <= '0;
      bit_cnt_q <= '0;
      word_left_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      word_left_q <= word_left_d;
      aborted_q <= aborted_d;
    end
  end
  // abort gates the handshake and the shift enable in the same cycle so nothing moves on the abort edge
  assign cfg_ready = state_q == LOAD && !abort;
  assign chain_en = state_q == SHIFT && !abort;
  assign ccff_head = state_q == SHIFT && sreg_q[WORD_W-1];
  assign busy = in_run;
  assign done = state_q == DONE;
  assign aborted = aborted_q;
  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb (
    .prog_clk(prog_clk),
    .reset(reset),
    .bit_in(ccff_tail),
    .en(chain_en),
    .flush(chain_en && last_bit),
    .clr(rb_clr),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
  );
endmodule
